// File: rtl/mc_core_param.sv
// rtl/mc_core_param.sv - parametrised multicycle core with req/ready single-port memory
// Optional perf counters (retired, stall_count) are built when MC_CORE_PERF_EN is defined.
module mc_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_n,
  output logic              flag_z,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
  } state_t;

  state_t            state;
  logic [7:0]        ir;
  logic [DATA_W-1:0] k [4];
  logic [DATA_W-1:0] a, b, alu_out;

  logic [1:0] r1, r2;
  logic [3:0] op;
  logic       is_load, is_store, is_ori, is_shift, is_alu, is_branch, is_stop;

  assign r1        = ir[7:6];
  assign r2        = ir[5:4];
  assign op        = ir[3:0];
  assign is_load   = (op == 4'b0000);
  assign is_store  = (op == 4'b0010);
  assign is_ori    = (ir[2:0] == 3'b111);
  assign is_shift  = (ir[2:0] == 3'b011);
  assign is_alu    = (op == 4'b0100) || (op == 4'b0110) || (op == 4'b1000) || is_ori || is_shift;
  assign is_branch = (op == 4'b0101) || (op == 4'b1001) || (op == 4'b1101);
  assign is_stop   = (op == 4'b0001);

  logic [DATA_W-1:0] alu_res;
  logic              take;
  logic [ADDR_W-1:0] br_off;

  always_comb begin
    alu_res = '0;
    if (is_ori)
      alu_res = k[1] | DATA_W'(ir[7:3]);
    else if (is_shift)
      alu_res = ir[5] ? (a >> ir[4:3]) : (a << ir[4:3]);
    else begin
      case (op)
        4'b0100: alu_res = a + b;
        4'b0110: alu_res = a - b;
        4'b1000: alu_res = ~(a & b);
        default: alu_res = '0;
      endcase
    end
  end

  always_comb begin
    case (op)
      4'b0101: take = flag_z;
      4'b1001: take = !flag_z;
      4'b1101: take = !flag_n;
      default: take = 1'b0;
    endcase
  end

  // offset applies to the PC already advanced past the branch
  assign br_off = ADDR_W'($signed(ir[7:4]));

  // memory port depends only on state and registers
  assign mem_req   = (state == S_FETCH) || (state == S_MEM);
  assign mem_we    = (state == S_MEM) && is_store;
  assign mem_addr  = (state == S_FETCH) ? pc : ((state == S_MEM) ? b[ADDR_W-1:0] : '0);
  assign mem_wdata = (state == S_MEM) ? a : '0;
  assign halted    = (state == S_HALT);
  assign dbg_data  = k[dbg_sel];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      pc      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      for (int i = 0; i < 4; i++) k[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata[7:0];
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a <= k[r1];
          b <= k[r2];
          if (is_load || is_store) state <= S_MEM;
          else if (is_alu)         state <= S_EXEC;
          else if (is_branch)      state <= S_BRANCH;
          else if (is_stop)        state <= S_HALT;
          else                     state <= S_FETCH;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          flag_n  <= alu_res[DATA_W-1];
          flag_z  <= (alu_res == '0);
          state   <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_store) state <= S_FETCH;
            else begin
              alu_out <= mem_rdata;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          k[is_ori ? 2'd1 : r1] <= alu_out;
          state <= S_FETCH;
        end
        S_BRANCH: begin
          if (take) pc <= pc + br_off;
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cycle_count <= '0;
    else if (state != S_IDLE && state != S_HALT && cycle_count != {CNT_W{1'b1}})
      cycle_count <= cycle_count + CNT_W'(1);
  end

`ifdef MC_CORE_PERF_EN
  logic is_nop, retire_now, stall_now;
  assign is_nop     = !(is_load || is_store || is_alu || is_branch || is_stop);
  assign retire_now = (state == S_WB) || (state == S_BRANCH) ||
                      (state == S_MEM && mem_ready && is_store) ||
                      (state == S_DECODE && is_nop);
  assign stall_now  = mem_req && !mem_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired     <= '0;
      stall_count <= '0;
    end else begin
      if (retire_now && retired != {CNT_W{1'b1}})
        retired <= retired + CNT_W'(1);
      if (stall_now && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`else
  assign retired     = '0;
  assign stall_count = '0;
`endif

endmodule
